pma_router: RTL



---
 rtl/pma_router_pkg.sv | 29 ++
 rtl/pma_router.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pma_router_pkg.sv
// Shared types and defaults for the PMA-driven memory request router.
// Route states, request/response payload records and the watchdog default.
package pma_router_pkg;

    localparam int unsigned XLEN_DEF           = 32;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CACHE_REQ  = 3'd1,
        CACHE_WAIT = 3'd2,
        UNC_REQ    = 3'd3,
        UNC_WAIT   = 3'd4,
        RESP       = 3'd5
    } route_state_e;

    typedef struct packed {
        logic [XLEN_DEF-1:0]   addr;
        logic                  we;
        logic [XLEN_DEF-1:0]   wdata;
        logic [XLEN_DEF/8-1:0] wstrb;
    } mem_req_t;

    typedef struct packed {
        logic [XLEN_DEF-1:0] rdata;
        logic                err;
    } mem_rsp_t;

endpackage

// File: rtl/pma_router.sv
// Steers one core request at a time to the cache or uncached bus using the
// combinational pma attributes; denied accesses fault without bus traffic.
module pma_router
    import pma_router_pkg::*;
#(
    parameter int unsigned XLEN           = XLEN_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [XLEN-1:0]   req_addr_i,
    input  logic              req_we_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    input  logic [XLEN/8-1:0] req_wstrb_i,

    output logic              rsp_valid_o,
    output logic [XLEN-1:0]   rsp_rdata_o,
    output logic              rsp_err_o,

    output logic [XLEN-1:0]   pma_addr_o,
    input  logic              pma_uncached_i,
    input  logic              pma_memregion_i,
    input  logic              pma_grand_i,

    output logic [XLEN-1:0]   mem_addr_o,
    output logic              mem_we_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [XLEN/8-1:0] mem_wstrb_o,

    output logic              cache_req_valid_o,
    input  logic              cache_req_ready_i,
    input  logic              cache_rsp_valid_i,
    input  logic [XLEN-1:0]   cache_rdata_i,
    input  logic              cache_err_i,

    output logic              unc_req_valid_o,
    input  logic              unc_req_ready_i,
    input  logic              unc_rsp_valid_i,
    input  logic [XLEN-1:0]   unc_rdata_i,
    input  logic              unc_err_i,

    output route_state_e      dbg_state_o
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready
    // are both high; valid never depends on ready and payload holds while valid.

    localparam int unsigned CW = 32;
    localparam logic [CW-1:0] TMO_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

    route_state_e      state_q, state_d;
    logic [CW-1:0]     tmo_cnt_q;
    logic [XLEN-1:0]   addr_q, wdata_q, rdata_q;
    logic              we_q, err_q;
    logic [XLEN/8-1:0] wstrb_q;

    logic in_unc, tmo_hit, accept;

    assign in_unc  = (state_q == UNC_REQ) || (state_q == UNC_WAIT);
    // tmo_hit marks the last permitted cycle in UNC_REQ/UNC_WAIT
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && in_unc && (tmo_cnt_q >= TMO_LAST);
    assign accept  = (state_q == IDLE) && req_valid_i;

    always_comb begin
        state_d           = state_q;
        req_ready_o       = 1'b0;
        cache_req_valid_o = 1'b0;
        unc_req_valid_o   = 1'b0;
        rsp_valid_o       = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    if (!pma_grand_i)
                        state_d = RESP;
                    else if (pma_uncached_i || !pma_memregion_i)
                        state_d = UNC_REQ;
                    else
                        state_d = CACHE_REQ;
                end
            end
            CACHE_REQ: begin
                cache_req_valid_o = 1'b1;
                if (cache_req_ready_i) state_d = CACHE_WAIT;
            end
            CACHE_WAIT: begin
                if (cache_rsp_valid_i) state_d = RESP;
            end
            UNC_REQ: begin
                // valid is withdrawn on expiry so no handshake races the abort
                unc_req_valid_o = !tmo_hit;
                if (tmo_hit)              state_d = RESP;
                else if (unc_req_ready_i) state_d = UNC_WAIT;
            end
            UNC_WAIT: begin
                if (unc_rsp_valid_i || tmo_hit) state_d = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= '0;
        end else if (!in_unc) begin
            tmo_cnt_q <= '0;
        end else if (tmo_cnt_q != '1) begin
            tmo_cnt_q <= tmo_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (accept) begin
            addr_q  <= req_addr_i;
            we_q    <= req_we_i;
            wdata_q <= req_wdata_i;
            wstrb_q <= req_wstrb_i;
        end
    end

    // A real uncached response in the expiry cycle takes precedence
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            rdata_q <= '0;
            err_q   <= !pma_grand_i;
        end else if ((state_q == CACHE_WAIT) && cache_rsp_valid_i) begin
            rdata_q <= (we_q || cache_err_i) ? '0 : cache_rdata_i;
            err_q   <= cache_err_i;
        end else if ((state_q == UNC_WAIT) && unc_rsp_valid_i) begin
            rdata_q <= (we_q || unc_err_i) ? '0 : unc_rdata_i;
            err_q   <= unc_err_i;
        end else if (tmo_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
        end
    end

    assign pma_addr_o  = req_addr_i;
    assign mem_addr_o  = addr_q;
    assign mem_we_o    = we_q;
    assign mem_wdata_o = wdata_q;
    assign mem_wstrb_o = wstrb_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign dbg_state_o = state_q;

endmodule
